// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Brief    : Stage register fields and control strobes between the pipeline
//            datapath and the hazard controller.
// Revision : 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if;
  // ID stage
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_is_md;
  logic       id_md_div;
  logic       id_reads_hilo;
  // Later stage destinations
  logic [4:0] ex_rd;
  logic [4:0] mem_rd;
  logic [4:0] wb_rd;
  logic       ex_reg_write;
  logic       mem_reg_write;
  logic       wb_reg_write;
  logic       ex_mem_load;
  // Controller outputs
  logic       pc_le;
  logic       if_id_le;
  logic       id_ex_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       md_start;
  logic       md_busy;
  logic       hilo_we;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md, id_md_div,
           id_reads_hilo, ex_rd, mem_rd, wb_rd, ex_reg_write, mem_reg_write,
           wb_reg_write, ex_mem_load,
    input  pc_le, if_id_le, id_ex_bubble, fwd_a, fwd_b, md_start, md_busy,
           hilo_we
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md, id_md_div,
           id_reads_hilo, ex_rd, mem_rd, wb_rd, ex_reg_write, mem_reg_write,
           wb_reg_write, ex_mem_load,
    output pc_le, if_id_le, id_ex_bubble, fwd_a, fwd_b, md_start, md_busy,
           hilo_we
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Load-use / RAW interlock, operand forwarding select and mult/div
//            occupancy sequencer. Define PIPE_CTRL_FWD_EN to enable forwarding.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hilo_we_q, hilo_we_d;

  logic       ex_match_a, ex_match_b;
  logic       mem_match_a, mem_match_b;
  logic       load_use_stall;
  logic       md_stall;
  logic       data_stall;
  logic       stall;
  logic       md_start;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  always_comb begin
    ex_match_a  = bus.ex_reg_write && (bus.ex_rd != 5'd0) &&
                  bus.id_uses_rs && (bus.ex_rd == bus.id_rs);
    ex_match_b  = bus.ex_reg_write && (bus.ex_rd != 5'd0) &&
                  bus.id_uses_rt && (bus.ex_rd == bus.id_rt);
    mem_match_a = bus.mem_reg_write && (bus.mem_rd != 5'd0) &&
                  bus.id_uses_rs && (bus.mem_rd == bus.id_rs);
    mem_match_b = bus.mem_reg_write && (bus.mem_rd != 5'd0) &&
                  bus.id_uses_rt && (bus.mem_rd == bus.id_rt);
  end

`ifdef PIPE_CTRL_FWD_EN
  logic wb_match_a, wb_match_b;

  always_comb begin
    wb_match_a = bus.wb_reg_write && (bus.wb_rd != 5'd0) &&
                 bus.id_uses_rs && (bus.wb_rd == bus.id_rs);
    wb_match_b = bus.wb_reg_write && (bus.wb_rd != 5'd0) &&
                 bus.id_uses_rt && (bus.wb_rd == bus.id_rt);
  end

  // Youngest producer wins; a load in EX has no data yet and is interlocked.
  always_comb begin
    data_stall = 1'b0;
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
    if (ex_match_a && !bus.ex_mem_load) fwd_a_sel = 2'b01;
    else if (mem_match_a)               fwd_a_sel = 2'b10;
    else if (wb_match_a)                fwd_a_sel = 2'b11;
    if (ex_match_b && !bus.ex_mem_load) fwd_b_sel = 2'b01;
    else if (mem_match_b)               fwd_b_sel = 2'b10;
    else if (wb_match_b)                fwd_b_sel = 2'b11;
  end
`else
  // WB producers need no interlock: the register file writes before it reads.
  logic wb_unused;
  assign wb_unused = &{1'b0, bus.wb_rd, bus.wb_reg_write};

  always_comb begin
    data_stall = ex_match_a | ex_match_b | mem_match_a | mem_match_b;
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
  end
`endif

  always_comb begin
    load_use_stall = (ex_match_a | ex_match_b) & bus.ex_mem_load;
    md_stall       = (state_q != MD_IDLE) & (bus.id_is_md | bus.id_reads_hilo);
    stall          = load_use_stall | md_stall | data_stall;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hilo_we_d = 1'b0;
    md_start  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (bus.id_is_md && !stall) begin
          md_start = 1'b1;
          cnt_d    = bus.id_md_div ? DIV_LOAD : MULT_LOAD;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d   = MD_DONE;
          hilo_we_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= 4'd0;
      hilo_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hilo_we_q <= hilo_we_d;
    end
  end

  // Combinational outputs are forced to their idle values while reset is low.
  assign bus.pc_le        = reset & ~stall;
  assign bus.if_id_le     = reset & ~stall;
  assign bus.id_ex_bubble = ~reset | stall;
  assign bus.fwd_a        = reset ? fwd_a_sel : 2'b00;
  assign bus.fwd_b        = reset ? fwd_b_sel : 2'b00;
  assign bus.md_start     = reset & md_start;
  assign bus.md_busy      = (state_q != MD_IDLE);
  assign bus.hilo_we      = hilo_we_q;

  a_no_start_in_stall : assert property (
    @(posedge clk) disable iff (!reset) md_start |-> !stall);

  a_hilo_only_in_done : assert property (
    @(posedge clk) disable iff (!reset) hilo_we_q |-> (state_q == MD_DONE));

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_CTRL_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  pipeline_hazard_ctrl_if u_if ();

  pipeline_hazard_ctrl #(
    .MULT_CYCLES (4),
    .DIV_CYCLES  (8)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.id_rs         = 5'd0;
    u_if.id_rt         = 5'd0;
    u_if.id_uses_rs    = 1'b0;
    u_if.id_uses_rt    = 1'b0;
    u_if.id_is_md      = 1'b0;
    u_if.id_md_div     = 1'b0;
    u_if.id_reads_hilo = 1'b0;
    u_if.ex_rd         = 5'd0;
    u_if.mem_rd        = 5'd0;
    u_if.wb_rd         = 5'd0;
    u_if.ex_reg_write  = 1'b0;
    u_if.mem_reg_write = 1'b0;
    u_if.wb_reg_write  = 1'b0;
    u_if.ex_mem_load   = 1'b0;
  endtask

  task automatic check_ctrl(input string tag, input logic exp_stall);
    check_val({tag, "_pc_le"},    32'(u_if.pc_le),        32'(!exp_stall));
    check_val({tag, "_if_id_le"}, 32'(u_if.if_id_le),     32'(!exp_stall));
    check_val({tag, "_bubble"},   32'(u_if.id_ex_bubble), 32'(exp_stall));
  endtask

  task automatic check_reset_vals(input string tag);
    check_ctrl(tag, 1'b1);
    check_val({tag, "_fwd_a"},    32'(u_if.fwd_a),    32'd0);
    check_val({tag, "_fwd_b"},    32'(u_if.fwd_b),    32'd0);
    check_val({tag, "_md_start"}, 32'(u_if.md_start), 32'd0);
    check_val({tag, "_md_busy"},  32'(u_if.md_busy),  32'd0);
    check_val({tag, "_hilo_we"},  32'(u_if.hilo_we),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset with hazards and a mult on the inputs: everything must stay idle
    reset = 1'b0;
    clear_inputs();
    u_if.mem_rd = 5'd3; u_if.mem_reg_write = 1'b1;
    u_if.id_rs = 5'd3;  u_if.id_uses_rs = 1'b1;
    u_if.id_is_md = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");

    reset = 1'b1;
    clear_inputs();
    #1;
    check_ctrl("idle", 1'b0);
    check_val("idle_fwd_a", 32'(u_if.fwd_a), 32'd0);

    // Load-use: one bubble, then the load sits in MEM
    tick();
    u_if.ex_rd = 5'd5; u_if.ex_reg_write = 1'b1; u_if.ex_mem_load = 1'b1;
    u_if.id_rs = 5'd5; u_if.id_uses_rs = 1'b1;
    #1;
    check_ctrl("lu", 1'b1);
    tick();
    clear_inputs();
    u_if.mem_rd = 5'd5; u_if.mem_reg_write = 1'b1;
    u_if.id_rs = 5'd5;  u_if.id_uses_rs = 1'b1;
    #1;
    check_val("lu_next_fwd_a", 32'(u_if.fwd_a), FWD_ON ? 32'd2 : 32'd0);
    check_ctrl("lu_next", !FWD_ON);

    // EX beats MEM; register 0 never forwards
    tick();
    clear_inputs();
    u_if.ex_rd = 5'd7;  u_if.ex_reg_write = 1'b1;
    u_if.mem_rd = 5'd7; u_if.mem_reg_write = 1'b1;
    u_if.id_rt = 5'd7;  u_if.id_uses_rt = 1'b1;
    #1;
    check_val("exmem_fwd_b", 32'(u_if.fwd_b), FWD_ON ? 32'd1 : 32'd0);
    check_ctrl("exmem", !FWD_ON);
    u_if.ex_rd = 5'd0; u_if.mem_rd = 5'd0; u_if.id_rt = 5'd0;
    #1;
    check_val("r0_fwd_b", 32'(u_if.fwd_b), 32'd0);
    check_ctrl("r0", 1'b0);

    // WB-only source, then MEM over WB, then operand not used
    tick();
    clear_inputs();
    u_if.wb_rd = 5'd9; u_if.wb_reg_write = 1'b1;
    u_if.id_rs = 5'd9; u_if.id_uses_rs = 1'b1;
    #1;
    check_val("wb_fwd_a", 32'(u_if.fwd_a), FWD_ON ? 32'd3 : 32'd0);
    check_ctrl("wb", 1'b0);
    u_if.mem_rd = 5'd9; u_if.mem_reg_write = 1'b1;
    #1;
    check_val("memwb_fwd_a", 32'(u_if.fwd_a), FWD_ON ? 32'd2 : 32'd0);
    check_ctrl("memwb", !FWD_ON);
    u_if.id_uses_rs = 1'b0;
    #1;
    check_val("nouse_fwd_a", 32'(u_if.fwd_a), 32'd0);
    check_ctrl("nouse", 1'b0);

    // mult (4 cycles) with mfhi arriving two cycles later
    tick();
    clear_inputs();
    u_if.id_is_md = 1'b1;
    #1;
    check_val("mul_start", 32'(u_if.md_start), 32'd1);
    check_ctrl("mul_issue", 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      clear_inputs();
      if (k >= 2) u_if.id_reads_hilo = 1'b1;
      #1;
      check_val($sformatf("mul_busy_%0d", k),  32'(u_if.md_busy),  32'(k <= 5));
      check_val($sformatf("mul_hilo_%0d", k),  32'(u_if.hilo_we),  32'(k == 5));
      check_val($sformatf("mul_start_%0d", k), 32'(u_if.md_start), 32'd0);
      check_val($sformatf("mfhi_pc_le_%0d", k), 32'(u_if.pc_le), 32'(!(k >= 2 && k <= 5)));
    end

    // div (8 cycles) runs to completion
    tick();
    clear_inputs();
    u_if.id_is_md = 1'b1; u_if.id_md_div = 1'b1;
    #1;
    check_val("div_start", 32'(u_if.md_start), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      clear_inputs();
      #1;
      check_val($sformatf("div_busy_%0d", k), 32'(u_if.md_busy), 32'(k <= 9));
      check_val($sformatf("div_hilo_%0d", k), 32'(u_if.hilo_we), 32'(k == 9));
    end

    // div aborted by reset four cycles in
    tick();
    u_if.id_is_md = 1'b1; u_if.id_md_div = 1'b1;
    #1;
    check_val("abort_start", 32'(u_if.md_start), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      clear_inputs();
    end
    reset = 1'b0;
    u_if.id_is_md = 1'b1;
    u_if.mem_rd = 5'd3; u_if.mem_reg_write = 1'b1;
    u_if.id_rs = 5'd3;  u_if.id_uses_rs = 1'b1;
    #1;
    check_reset_vals("abort_rst");
    tick();
    tick();
    check_reset_vals("abort_hold");
    reset = 1'b1;
    clear_inputs();
    tick();
    check_val("abort_idle", 32'(u_if.md_busy), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_val($sformatf("abort_hilo_%0d", k), 32'(u_if.hilo_we), 32'd0);
    end

    // Load-use coincident with a mult: issue slips one cycle
    tick();
    u_if.ex_rd = 5'd4; u_if.ex_reg_write = 1'b1; u_if.ex_mem_load = 1'b1;
    u_if.id_rs = 5'd4; u_if.id_uses_rs = 1'b1;
    u_if.id_is_md = 1'b1;
    #1;
    check_val("lu_md_start", 32'(u_if.md_start), 32'd0);
    check_ctrl("lu_md", 1'b1);
    tick();
    clear_inputs();
    u_if.wb_rd = 5'd4; u_if.wb_reg_write = 1'b1;
    u_if.id_rs = 5'd4; u_if.id_uses_rs = 1'b1;
    u_if.id_is_md = 1'b1;
    #1;
    check_val("lu_md_start_next", 32'(u_if.md_start), 32'd1);
    check_ctrl("lu_md_next", 1'b0);
    tick();
    clear_inputs();
    u_if.id_is_md = 1'b1;
    #1;
    check_val("md_while_busy_start", 32'(u_if.md_start), 32'd0);
    check_ctrl("md_while_busy", 1'b1);
    clear_inputs();
    repeat (6) tick();
    check_val("md_drain_busy", 32'(u_if.md_busy), 32'd0);

    // MEM match interlocks only without forwarding; WB never does
    clear_inputs();
    u_if.mem_rd = 5'd3; u_if.mem_reg_write = 1'b1;
    u_if.id_rs = 5'd3;  u_if.id_uses_rs = 1'b1;
    #1;
    check_val("mem3_fwd_a", 32'(u_if.fwd_a), FWD_ON ? 32'd2 : 32'd0);
    check_ctrl("mem3", !FWD_ON);
    tick();
    clear_inputs();
    u_if.wb_rd = 5'd3; u_if.wb_reg_write = 1'b1;
    u_if.id_rs = 5'd3; u_if.id_uses_rs = 1'b1;
    #1;
    check_val("wb3_fwd_a", 32'(u_if.fwd_a), FWD_ON ? 32'd3 : 32'd0);
    check_ctrl("wb3", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4: execution cycles of a mult/multu (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 8: execution cycles of a div/divu (legal range 1..15).
REQ-003 SHALL have the following ports; clk is the single clock, and reset is asynchronous and active-low:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_is_md  in  1  ID instruction is mult/div
- id_md_div  in  1  1 = divide, 0 = multiply (valid with id_is_md)
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_rd, mem_rd, wb_rd  in  5 each  WriteDestination of EX / MEM / WB
- ex_reg_write, mem_reg_write, wb_reg_write  in  1 each  stage writes the register file
- ex_mem_load  in  1  EX instruction is a load
- pc_le  out  1  PC load enable
- if_id_le  out  1  IF/ID load enable
- id_ex_bubble  out  1  load NOP control word into ID/EX
- fwd_a, fwd_b  out  2 each  ID operand mux select for rs / rt: 00 regfile, 01 EX, 10 MEM, 11 WB
- md_start  out  1  one-cycle pulse launching mult/div
- md_busy  out  1  mult/div unit occupied
- hilo_we  out  1  one-cycle HI/LO write strobe

Function
REQ-004 SHALL raise a match for stage S and operand X when S_reg_write=1, S_rd!=0, id_uses_X=1 and S_rd==id_X.
REQ-005 SHALL raise a load-use stall when an EX match exists on either operand and ex_mem_load=1.
REQ-006 SHALL raise an MD stall when md_busy=1 and (id_is_md=1 or id_reads_hilo=1).
REQ-007 SHALL set stall = load-use stall OR MD stall OR (REQ-015 stall); when stall=1, pc_le=0, if_id_le=0, id_ex_bubble=1, all combinationally in the same cycle; otherwise pc_le=1, if_id_le=1, id_ex_bubble=0.
REQ-008 SHALL drive fwd_a and fwd_b combinationally with priority EX (01, non-load only) > MEM (10) > WB (11) > 00; register 0 SHALL never be forwarded.
REQ-009 SHALL implement an MD FSM with states IDLE, BUSY and DONE, plus a 4-bit down-counter.
REQ-010 In IDLE, when id_is_md=1 and stall=0 (cycle T), the block SHALL assert md_start for that cycle only and load the counter with (id_md_div ? DIV_CYCLES : MULT_CYCLES)-1; the FSM SHALL be in BUSY from T+1.
REQ-011 In BUSY, the counter SHALL decrement each cycle; when the counter is 0, the next state SHALL be DONE, so BUSY lasts exactly N cycles (T+1..T+N).
REQ-012 In DONE (T+N+1), hilo_we SHALL be 1 for exactly one cycle (registered, Moore), and the next state SHALL be IDLE.
REQ-013 md_busy SHALL be 1 in BUSY and DONE; an mfhi/mflo or a new mult/div in ID SHALL be released at T+N+2.
REQ-014 A load-use stall and an MD stall in the same cycle SHALL produce a single stall; md_start SHALL never assert while stall=1.

Configuration
REQ-015 With macro PIPE_CTRL_FWD_EN defined, forwarding SHALL operate as in REQ-008.
REQ-016 Without PIPE_CTRL_FWD_EN, fwd_a and fwd_b SHALL be tied to 00, and any EX or MEM match SHALL stall as in REQ-007; WB matches rely on the register file's write-first behaviour.

Reset
REQ-017 While reset=0, the FSM SHALL be IDLE, the counter 0, md_start=0, hilo_we=0, md_busy=0, pc_le=0, if_id_le=0, id_ex_bubble=1 and fwd_a=fwd_b=00.
REQ-018 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation without issuing hilo_we, and the FSM SHALL be IDLE on the first clock after release.

Verification
REQ-019 Load in EX with ex_rd=5, and ID id_rs=5 with uses_rs=1 -> one cycle with pc_le=0, if_id_le=0, id_ex_bubble=1; the next cycle, with the load in MEM, fwd_a=10 and no stall.
REQ-020 ex_rd=mem_rd=7 (both non-load, reg_write=1), id_rt=7 -> fwd_b=01; with ex_rd=0 and id_rt=0 -> fwd_b=00.
REQ-021 mult in ID at cycle 10 with MULT_CYCLES=4 -> md_start at 10, md_busy 11..15, hilo_we only at 15; mfhi in ID at 12 stalls through 15 and proceeds at 16.
REQ-022 div accepted at 20 (DIV_CYCLES=8), reset pulsed low at 24 -> no hilo_we, IDLE after release, outputs at reset values while reset=0.
REQ-023 Load-use stall coincident with mult in ID while IDLE -> no md_start that cycle; md_start the following cycle.
REQ-024 Built without PIPE_CTRL_FWD_EN, mem_rd=3 and id_rs=3 -> stall=1 and fwd_a=00; wb_rd=3 match only -> no stall.
